// File: rtl/cp0_irq_ctrl.sv
// CP0 register file and interrupt controller: BadVAddr, Count, Compare,
// Status, Cause, EPC, PRId; timer + hw interrupts, exception entry, ERET.
// Ports: clk, rst (sync, high); raddr/rdata read port with write bypass;
// we/waddr/wdata MTC0; hw_int; except_*; eret; int_req, epc_o, status_o,
// cause_o.
module cp0_irq_ctrl #(
  parameter int          N_HW_INT     = 6,
  parameter int          COUNT_DIV    = 2,
  parameter logic [31:0] PRID_VALUE   = 32'h0001_8000,
  parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          raddr,
  output logic [31:0]         rdata,
  input  logic                we,
  input  logic [4:0]          waddr,
  input  logic [31:0]         wdata,
  input  logic [N_HW_INT-1:0] hw_int,
  input  logic                except_valid,
  input  logic [4:0]          except_code,
  input  logic [31:0]         except_pc,
  input  logic                except_delayslot,
  input  logic [31:0]         except_badvaddr,
  input  logic                eret,
  output logic                int_req,
  output logic [31:0]         epc_o,
  output logic [31:0]         status_o,
  output logic [31:0]         cause_o
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);
  localparam logic [31:0]   ST_MASK   = 32'h0000_FF03;

  localparam logic [4:0] A_BADV = 5'd8;
  localparam logic [4:0] A_CNT  = 5'd9;
  localparam logic [4:0] A_CMP  = 5'd11;
  localparam logic [4:0] A_ST   = 5'd12;
  localparam logic [4:0] A_CAU  = 5'd13;
  localparam logic [4:0] A_EPC  = 5'd14;
  localparam logic [4:0] A_PRID = 5'd15;

  logic [31:0]   r_badv, r_count, r_compare, r_status, r_epc;
  logic [PW-1:0] r_presc;
  logic          r_ti, r_bd;
  logic [1:0]    r_sw;
  logic [5:0]    r_hw;
  logic [4:0]    r_exc;

  logic [31:0]   n_badv, n_count, n_compare, n_status, n_epc;
  logic [PW-1:0] n_presc;
  logic          n_ti, n_bd;
  logic [1:0]    n_sw;
  logic [4:0]    n_exc;

  logic [5:0]    w_hw;
  logic          w_tick;
  logic [31:0]   w_cnt_inc;
  logic [7:0]    w_ip;
  logic [31:0]   w_cause;
  logic [31:0]   w_byp_cause;
  logic [31:0]   w_byp_status;
  logic [31:0]   w_rd_cur;
  logic [31:0]   w_rd_byp;

  // Zero-extended so unused IP positions read 0 for small N_HW_INT;
  // bit 5 is only ever non-zero when N_HW_INT == 6.
  assign w_hw      = 6'(hw_int);
  assign w_tick    = (r_presc == PRESC_MAX);
  assign w_cnt_inc = r_count + 32'd1;

  assign w_ip    = {r_hw[5] | r_ti, r_hw[4:0], r_sw};
  assign w_cause = {r_bd, r_ti, 2'b00, 12'h000,
                    w_ip, 1'b0, r_exc, 2'b00};

  assign w_byp_cause  = {w_cause[31:10], wdata[1:0], w_cause[7:0]};
  assign w_byp_status = (r_status & ~ST_MASK) | (wdata & ST_MASK);

  function automatic logic [31:0] rd_mux(
    input logic [4:0]  a,
    input logic [31:0] badv,
    input logic [31:0] cnt,
    input logic [31:0] cmp,
    input logic [31:0] st,
    input logic [31:0] cau,
    input logic [31:0] epc
  );
    logic [31:0] d;
    d = 32'h0;
    unique case (a)
      A_BADV:  d = badv;
      A_CNT:   d = cnt;
      A_CMP:   d = cmp;
      A_ST:    d = st;
      A_CAU:   d = cau;
      A_EPC:   d = epc;
      A_PRID:  d = PRID_VALUE;
      default: d = 32'h0;
    endcase
    return d;
  endfunction

  assign w_rd_cur = rd_mux(raddr, r_badv, r_count, r_compare,
                           r_status, w_cause, r_epc);
  assign w_rd_byp = rd_mux(raddr, r_badv, wdata, wdata,
                           w_byp_status, w_byp_cause, wdata);
  assign rdata = (we && waddr == raddr) ? w_rd_byp : w_rd_cur;

  assign int_req  = r_status[0] & ~r_status[1]
                  & |(w_ip & r_status[15:8]);
  assign epc_o    = r_epc;
  assign status_o = r_status;
  assign cause_o  = w_cause;

  always_comb begin
    n_presc   = w_tick ? '0 : r_presc + PW'(1);
    n_count   = w_tick ? w_cnt_inc : r_count;
    n_ti      = r_ti | (w_tick && (w_cnt_inc == r_compare));
    n_compare = r_compare;
    n_status  = r_status;
    n_sw      = r_sw;
    n_epc     = r_epc;
    n_bd      = r_bd;
    n_exc     = r_exc;
    n_badv    = r_badv;

    if (we) begin
      unique case (waddr)
        A_CNT: begin
          // A load replaces the increment, so it can never raise TI.
          n_count = wdata;
          n_presc = '0;
          n_ti    = r_ti;
        end
        A_CMP: begin
          n_compare = wdata;
          n_ti      = 1'b0;
        end
        A_ST:    n_status = w_byp_status;
        A_CAU:   n_sw     = wdata[1:0];
        A_EPC:   n_epc    = wdata;
        default: ;
      endcase
    end

    if (eret)
      n_status[1] = 1'b0;

    // EXL tested after write and ERET, so ERET+exception records EPC.
    if (except_valid) begin
      if (!n_status[1]) begin
        n_epc = except_delayslot ? except_pc - 32'd4 : except_pc;
        n_bd  = except_delayslot;
      end
      n_status[1] = 1'b1;
      n_exc       = except_code;
      if (except_code == 5'd4 || except_code == 5'd5)
        n_badv = except_badvaddr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_badv    <= 32'h0;
      r_count   <= 32'h0;
      r_compare <= 32'h0;
      r_status  <= STATUS_RESET;
      r_epc     <= 32'h0;
      r_presc   <= '0;
      r_ti      <= 1'b0;
      r_bd      <= 1'b0;
      r_sw      <= 2'b00;
      r_hw      <= 6'h00;
      r_exc     <= 5'h00;
    end else begin
      r_badv    <= n_badv;
      r_count   <= n_count;
      r_compare <= n_compare;
      r_status  <= n_status;
      r_epc     <= n_epc;
      r_presc   <= n_presc;
      r_ti      <= n_ti;
      r_bd      <= n_bd;
      r_sw      <= n_sw;
      r_hw      <= w_hw;
      r_exc     <= n_exc;
    end
  end

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Scoreboard bench for cp0_irq_ctrl: stimulus queues expectations,
// a negedge monitor pops and compares against the selected output.
module tb_cp0_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [5:0]  hw_int;
  logic        except_valid;
  logic [4:0]  except_code;
  logic [31:0] except_pc;
  logic        except_delayslot;
  logic [31:0] except_badvaddr;
  logic        eret;
  logic        int_req;
  logic [31:0] epc_o, status_o, cause_o;

  cp0_irq_ctrl dut (
    .clk(clk), .rst(rst),
    .raddr(raddr), .rdata(rdata),
    .we(we), .waddr(waddr), .wdata(wdata),
    .hw_int(hw_int),
    .except_valid(except_valid),
    .except_code(except_code),
    .except_pc(except_pc),
    .except_delayslot(except_delayslot),
    .except_badvaddr(except_badvaddr),
    .eret(eret),
    .int_req(int_req),
    .epc_o(epc_o), .status_o(status_o),
    .cause_o(cause_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       n;
    int          sel;
    logic [31:0] v;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] act;
  logic        chk_en = 1'b0;
  int          total = 0;
  int          bad = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL underflow: got no expectation, need one");
      end else begin
        e = sb.pop_front();
        case (e.sel)
          0: act = rdata;
          1: act = {31'h0, int_req};
          2: act = status_o;
          3: act = cause_o;
          default: act = epc_o;
        endcase
        if (act !== e.v) begin
          bad++;
          $display("FAIL %s: got %h need %h", e.n, act, e.v);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input int sel,
                     input logic [4:0] a, input logic [31:0] v);
    exp_t x;
    x.n = n; x.sel = sel; x.v = v;
    raddr = a;
    sb.push_back(x);
    chk_en = 1'b1;
    tick();
    chk_en = 1'b0;
  endtask

  task automatic chk_wr(input string n, input logic [4:0] a,
                        input logic [31:0] wv, input logic [31:0] v);
    we = 1'b1; waddr = a; wdata = wv;
    chk(n, 0, a, v);
    we = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] v);
    we = 1'b1; waddr = a; wdata = v;
    tick();
    we = 1'b0;
  endtask

  task automatic exc(input logic [4:0] c, input logic [31:0] pc,
                     input logic ds, input logic [31:0] bv,
                     input logic er);
    except_valid = 1'b1; except_code = c; except_pc = pc;
    except_delayslot = ds; except_badvaddr = bv; eret = er;
    tick();
    except_valid = 1'b0; eret = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, need finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; raddr = 5'd0; we = 1'b0; waddr = 5'd0;
    wdata = 32'h0; hw_int = 6'h0; except_valid = 1'b0;
    except_code = 5'd0; except_pc = 32'h0;
    except_delayslot = 1'b0; except_badvaddr = 32'h0;
    eret = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    chk("rst_status", 0, 5'd12, 32'h0040_0000);
    chk("rst_intreq", 1, 5'd0, 32'h0);
    chk("count_2cyc", 0, 5'd9, 32'd1);
    repeat (7) tick();
    chk("count_10cyc", 0, 5'd9, 32'd5);
    chk("rst_cause", 3, 5'd0, 32'h0);

    mtc0(5'd11, 32'd10);
    mtc0(5'd9, 32'd8);
    repeat (3) tick();
    chk("ti_before", 0, 5'd13, 32'h0);
    chk("ti_set", 0, 5'd13, 32'h4000_8000);
    chk("ti_noie", 1, 5'd0, 32'h0);
    mtc0(5'd12, 32'h0000_8001);
    chk("ti_intreq", 1, 5'd0, 32'h1);
    mtc0(5'd12, 32'h0000_8003);
    chk("ti_exl_mask", 1, 5'd0, 32'h0);
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd11, 32'd10);
    chk("ti_clr", 0, 5'd13, 32'h0);
    chk("ti_clr_int", 1, 5'd0, 32'h0);

    mtc0(5'd12, 32'hFFFF_FFFF);
    chk("st_mask", 0, 5'd12, 32'h0040_FF03);
    mtc0(5'd12, 32'h0);
    mtc0(5'd13, 32'hFFFF_FFFF);
    chk("cause_mask", 0, 5'd13, 32'h0000_0300);
    chk_wr("st_byp", 5'd12, 32'h1234_5601, 32'h0040_5601);
    chk("sw_intreq", 1, 5'd0, 32'h1);
    chk_wr("cnt_byp", 5'd9, 32'h0000_0055, 32'h0000_0055);
    mtc0(5'd15, 32'h0);
    chk("prid_ro", 0, 5'd15, 32'h0001_8000);
    mtc0(5'd3, 32'hDEAD_BEEF);
    chk("unmapped", 0, 5'd3, 32'h0);
    mtc0(5'd13, 32'h0);
    mtc0(5'd12, 32'h0000_0401);

    hw_int = 6'h01;
    chk("hw_lat", 1, 5'd0, 32'h0);
    chk("hw_int", 1, 5'd0, 32'h1);
    chk("hw_ip2", 3, 5'd0, 32'h0000_0400);
    hw_int = 6'h20;
    chk("hw_old", 3, 5'd0, 32'h0000_0400);
    chk("hw_ip7", 3, 5'd0, 32'h0000_8000);
    chk("hw_ip7_im", 1, 5'd0, 32'h0);
    hw_int = 6'h00;
    tick();

    exc(5'd4, 32'h8000_1004, 1'b1, 32'h13, 1'b0);
    chk("exc_epc", 4, 5'd0, 32'h8000_1000);
    chk("exc_cause", 3, 5'd0, 32'h8000_0010);
    chk("exc_status", 2, 5'd0, 32'h0040_0403);
    chk("exc_badv", 0, 5'd8, 32'h0000_0013);
    exc(5'd0, 32'h8000_2000, 1'b0, 32'h99, 1'b0);
    chk("exc2_epc", 4, 5'd0, 32'h8000_1000);
    chk("exc2_cause", 3, 5'd0, 32'h8000_0000);
    chk("exc2_badv", 0, 5'd8, 32'h0000_0013);

    exc(5'd5, 32'h8000_3000, 1'b0, 32'h44, 1'b1);
    chk("both_status", 2, 5'd0, 32'h0040_0403);
    chk("both_epc", 4, 5'd0, 32'h8000_3000);
    chk("both_cause", 3, 5'd0, 32'h0000_0014);
    chk("both_badv", 0, 5'd8, 32'h0000_0044);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    chk("eret_status", 2, 5'd0, 32'h0040_0401);

    mtc0(5'd9, 32'hFFFF_FFFF);
    chk("wrap_a", 0, 5'd9, 32'hFFFF_FFFF);
    chk("wrap_b", 0, 5'd9, 32'hFFFF_FFFF);
    chk("wrap_0", 0, 5'd9, 32'h0);

    rst = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'h77;
    tick();
    rst = 1'b0; we = 1'b0;
    chk("mid_rst_cnt", 0, 5'd9, 32'h0);
    chk("mid_rst_st", 2, 5'd0, 32'h0040_0000);
    chk("mid_rst_epc", 4, 5'd0, 32'h0);

    tick();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL leftover: got %0d need 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
